// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
// Bit period is CYCLES_PER_BIT+1 clocks; no flow control is involved.
package uart_pkg;

    localparam int CYCLES_PER_BIT_DEF = 434;
    localparam int DATA_BITS          = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line in, received byte and status pulses out; no backpressure on this bus.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 i_Rx;
    logic [DATA_BITS-1:0] o_Data;
    logic                 o_fDone;
    logic                 o_fFrameErr;
    logic                 o_fBusy;

    modport master (output i_Rx, input o_Data, o_fDone, o_fFrameErr, o_fBusy);
    modport slave  (input i_Rx, output o_Data, o_fDone, o_fFrameErr, o_fBusy);

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the idle-high serial line; 2-clock latency, resets to 1.
module uart_rx_sync (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_D,
    output logic o_Q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_meta <= 1'b1;
            r_q    <= 1'b1;
        end else begin
            r_meta <= i_D;
            r_q    <= r_meta;
        end
    end

    assign o_Q = r_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first; done/error pulse HALF_BIT+3+9*P clocks after first low sample, no backpressure.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting at each decision point.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_BIT = CYCLES_PER_BIT_DEF,
    parameter int HALF_BIT       = CYCLES_PER_BIT / 2
) (
    input  logic     i_Clk,
    input  logic     i_Rst,
    uart_rx_if.slave bus
);

    localparam logic [15:0] CNT_FULL = 16'(CYCLES_PER_BIT);
    localparam logic [15:0] CNT_HALF = 16'(HALF_BIT);
    localparam int          BW       = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 w_rx_s;
    logic                 w_sample;
    logic                 w_at_full;
    logic                 w_at_half;
    logic                 w_done_nxt;
    logic                 w_err_nxt;
    logic                 w_shift_en;
    state_t               r_state;
    state_t               w_state_nxt;
    logic [15:0]          r_clk_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_done;
    logic                 r_err;

    uart_rx_sync u_sync (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .i_D   (bus.i_Rx),
        .o_Q   (w_rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // History of the two previous rx_s values: at count N these hold N-1 and N-2.
    logic r_h1;
    logic r_h2;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_h1 <= 1'b1;
            r_h2 <= 1'b1;
        end else begin
            r_h1 <= w_rx_s;
            r_h2 <= r_h1;
        end
    end

    assign w_sample = maj3(r_h2, r_h1, w_rx_s);
`else
    assign w_sample = w_rx_s;
`endif

    assign w_at_full = (r_clk_cnt == CNT_FULL);
    assign w_at_half = (r_clk_cnt == CNT_HALF);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (!w_rx_s)                            w_state_nxt = START;
            START:   if (w_at_half)                          w_state_nxt = w_sample ? IDLE : DATA;
            DATA:    if (w_at_full && r_bit_cnt == LAST_BIT) w_state_nxt = STOP;
            STOP:    if (w_at_full)                          w_state_nxt = w_sample ? IDLE : BREAK;
            BREAK:   if (w_rx_s)                             w_state_nxt = IDLE;
            default:                                         w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_done_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        w_shift_en = 1'b0;
        case (r_state)
            DATA: w_shift_en = w_at_full;
            STOP: begin
                w_done_nxt = w_at_full &&  w_sample;
                w_err_nxt  = w_at_full && !w_sample;
            end
            default: ;
        endcase
    end

    // Counters restart on every state change so each state times from its own entry.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_state_nxt != r_state || w_at_full) r_clk_cnt <= '0;
            else                                     r_clk_cnt <= r_clk_cnt + 16'd1;

            if (w_state_nxt != r_state) r_bit_cnt <= '0;
            else if (w_shift_en)        r_bit_cnt <= r_bit_cnt + 1'b1;

            if (w_shift_en) r_shift <= {w_sample, r_shift[DATA_BITS-1:1]};
            if (w_done_nxt) r_data  <= r_shift;

            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
        end
    end

    assign bus.o_Data      = r_data;
    assign bus.o_fDone     = r_done;
    assign bus.o_fFrameErr = r_err;
    assign bus.o_fBusy     = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven cycle by cycle, expected pulses scoreboarded with their arrival cycle.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int P    = CYCLES_PER_BIT_DEF + 1;
    localparam int HALF = CYCLES_PER_BIT_DEF / 2;
    localparam int LAT  = HALF + 3 + 9 * P;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    logic [7:0] last_good = 8'h00;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uart_rx_if bus ();

    uart_rx dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard side: every pulse must match the oldest pending expectation.
    exp_t got;
    always @(posedge clk) begin
        #1;
        if (!rst && (bus.o_fDone || bus.o_fFrameErr)) begin
            chk("done_err_exclusive", {31'b0, bus.o_fDone & bus.o_fFrameErr}, 32'd0);
            chk("pulse_expected", {31'b0, q.size() > 0}, 32'd1);
            if (q.size() > 0) begin
                got = q.pop_front();
                chk("pulse_kind",  {31'b0, bus.o_fFrameErr}, {31'b0, got.err});
                chk("pulse_cycle", cyc, got.cyc);
                chk("pulse_data",  bus.o_Data, got.data);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.i_Rx = 1'b1;
        end
    endtask

    // Drives ncyc clocks of a frame; the value set at iteration c is sampled at posedge e0+c.
    task automatic send(input logic [7:0] b, input logic stopb, input int spike,
                        input int ncyc, input logic [7:0] expd, input bit track);
        logic [9:0] fr;
        exp_t       e;
        fr = {stopb, b, 1'b0};
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c == 0 && track) begin
                e.err  = !stopb;
                e.data = stopb ? expd : last_good;
                e.cyc  = cyc + 1 + LAT;
                q.push_back(e);
                if (stopb) last_good = expd;
            end
            bus.i_Rx = (c == spike) ? 1'b1 : fr[c / P];
        end
    endtask

    initial begin
        int         busy_cnt;
        logic [7:0] spike_exp;

        bus.i_Rx = 1'b1;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data",  bus.o_Data, 32'h00);
        chk("rst_done",  {31'b0, bus.o_fDone}, 32'd0);
        chk("rst_err",   {31'b0, bus.o_fFrameErr}, 32'd0);
        chk("rst_busy",  {31'b0, bus.o_fBusy}, 32'd0);
        rst = 1'b0;
        idle(20);

        send(8'h55, 1'b1, -1, 10 * P, 8'h55, 1'b1);
        chk("data_55", bus.o_Data, 32'h55);
        idle(10);

        send(8'hA3, 1'b1, -1, 10 * P, 8'hA3, 1'b1);
        chk("b2b_first", bus.o_Data, 32'hA3);
        send(8'h0F, 1'b1, -1, 10 * P, 8'h0F, 1'b1);
        chk("b2b_second", bus.o_Data, 32'h0F);
        idle(20);

        busy_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            bus.i_Rx = (c < 100) ? 1'b0 : 1'b1;
            if (bus.o_fBusy) busy_cnt++;
        end
        chk("glitch_busy_len", {31'b0, (busy_cnt > 0) && (busy_cnt <= HALF + 1)}, 32'd1);
        chk("glitch_idle", {31'b0, bus.o_fBusy}, 32'd0);
        chk("glitch_data", bus.o_Data, 32'h0F);

        send(8'h3C, 1'b0, -1, 10 * P, 8'h00, 1'b1);
        repeat (2000) begin
            @(negedge clk);
            bus.i_Rx = 1'b0;
        end
        chk("break_busy", {31'b0, bus.o_fBusy}, 32'd1);
        chk("break_data_kept", bus.o_Data, 32'h0F);
        @(negedge clk);
        bus.i_Rx = 1'b1;
        repeat (10) @(negedge clk);
        chk("break_exit", {31'b0, bus.o_fBusy}, 32'd0);
        idle(20);
        send(8'h81, 1'b1, -1, 10 * P, 8'h81, 1'b1);
        chk("after_break", bus.o_Data, 32'h81);
        idle(20);

        send(8'h5A, 1'b1, -1, 5 * P + P / 2, 8'h00, 1'b0);
        @(negedge clk);
        rst      = 1'b1;
        bus.i_Rx = 1'b1;
        #1;
        chk("midrst_data", bus.o_Data, 32'h00);
        chk("midrst_done", {31'b0, bus.o_fDone}, 32'd0);
        chk("midrst_err",  {31'b0, bus.o_fFrameErr}, 32'd0);
        chk("midrst_busy", {31'b0, bus.o_fBusy}, 32'd0);
        repeat (3) @(negedge clk);
        rst       = 1'b0;
        last_good = 8'h00;
        idle(20);
        send(8'hC7, 1'b1, -1, 10 * P, 8'hC7, 1'b1);
        chk("after_rst", bus.o_Data, 32'hC7);
        idle(20);

`ifdef UART_RX_MAJORITY_EN
        spike_exp = 8'h00;
`else
        spike_exp = 8'h04;
`endif
        send(8'h00, 1'b1, HALF + 1 + 3 * P, 10 * P, spike_exp, 1'b1);
        chk("spike_data", bus.o_Data, {24'b0, spike_exp});
        idle(20);

        chk("scoreboard_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
